// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator, its
// interface and anything that consumes the pixel counters.
package vga_timing_pkg;
   localparam int CNT_W = 10;

   localparam int VGA_H_DISPLAY = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_DISPLAY = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
   localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic in_span(cnt_t val, cnt_t lo, cnt_t hi);
      return (val >= lo) && (val <= hi);
   endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing outputs of the sync generator as seen by the pixel-colour blocks.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   cnt_t hcount;
   cnt_t vcount;
   logic hsync;
   logic vsync;
   logic video_on;
   logic p_tick;
   logic frame_start;

   modport master (output hcount, vcount, hsync, vsync, video_on, p_tick, frame_start);
   modport slave  (input  hcount, vcount, hsync, vsync, video_on, p_tick, frame_start);
endinterface

// File: rtl/vga_pix_tick.sv
// Divide-by-two pixel enable: a toggle flop, high on the first cycle after reset.
module vga_pix_tick (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tick <= 1'b0;
      else       tick <= ~tick;
   end
endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel/line counters plus sync, visible
// and frame-start flags, all registered on the same edge as the counters.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = VGA_H_DISPLAY,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_DISPLAY = VGA_V_DISPLAY,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
) (
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

   localparam cnt_t H_MAX    = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_MAX    = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
   localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
   localparam cnt_t HS_START = cnt_t'(H_DISPLAY + H_FP);
   localparam cnt_t HS_END   = cnt_t'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam cnt_t VS_START = cnt_t'(V_DISPLAY + V_FP);
   localparam cnt_t VS_END   = cnt_t'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic tick;
   cnt_t hcount, vcount, h_nxt, v_nxt;
   logic hsync, vsync, video_on, frame_start;
   logic hsync_nxt, vsync_nxt, video_on_nxt, frame_start_nxt;

   vga_pix_tick u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Flags decode the next-state counters so they land on the counter edge.
   always_comb begin
      h_nxt           = hcount;
      v_nxt           = vcount;
      frame_start_nxt = 1'b0;
      if (tick) begin
         if (hcount == H_MAX) begin
            h_nxt = '0;
            if (vcount == V_MAX) begin
               v_nxt           = '0;
               frame_start_nxt = 1'b1;
            end else begin
               v_nxt = vcount + cnt_t'(1);
            end
         end else begin
            h_nxt = hcount + cnt_t'(1);
         end
      end
      hsync_nxt    = ~in_span(h_nxt, HS_START, HS_END);
      vsync_nxt    = ~in_span(v_nxt, VS_START, VS_END);
      video_on_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         video_on    <= video_on_nxt;
         frame_start <= frame_start_nxt;
      end
   end

   assign vga.hcount      = hcount;
   assign vga.vcount      = vcount;
   assign vga.hsync       = hsync;
   assign vga.vsync       = vsync;
   assign vga.video_on    = video_on;
   assign vga.p_tick      = tick;
   assign vga.frame_start = frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size generator checked against a hand-computed vector table for
// its first lines; a shrunken instance checked each cycle over many frames.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   vga_sync_gen_if va ();
   vga_sync_gen_if vb ();

   vga_sync_gen dut_a (.clk(clk), .reset(rst_a), .vga(va));

   // Small frame: 15 pixels x 8 lines, hsync low h 10..12, vsync low v 5..6.
   vga_sync_gen #(
      .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_b (.clk(clk), .reset(rst_b), .vga(vb));

   always #5 clk = ~clk;

   typedef struct {
      int   n;
      int   h;
      int   v;
      logic hs;
      logic vs;
      logic von;
      logic pt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   na, nb, ti;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_b(input int n, output int h, output int v);
      int p;
      p = (n / 2) % 120;
      h = p % 15;
      v = p / 15;
   endfunction

   task automatic check_b(input int n);
      int h, v;
      logic hs, vs, von, fs;
      model_b(n, h, v);
      hs  = !(h >= 10 && h <= 12);
      vs  = !(v >= 5 && v <= 6);
      von = (h < 8) && (v < 4);
      fs  = (n > 0) && (n % 240 == 0);
      chk($sformatf("small_h n=%0d", n), vb.hcount, h);
      chk($sformatf("small_v n=%0d", n), vb.vcount, v);
      chk($sformatf("small_flags n=%0d", n),
          {vb.hsync, vb.vsync, vb.video_on, vb.p_tick, vb.frame_start},
          {hs, vs, von, logic'(n % 2), fs});
   endtask

   task automatic check_reset_vals(input string tag, input logic [9:0] h, input logic [9:0] v,
                                   input logic hs, input logic vs, input logic von,
                                   input logic pt, input logic fs);
      chk({tag, "_h"}, h, 0);
      chk({tag, "_v"}, v, 0);
      chk({tag, "_flags"}, {hs, vs, von, pt, fs}, 5'b11100);
   endtask

   task automatic apply_vecs();
      while (ti < tbl.size() && tbl[ti].n == na) begin
         chk($sformatf("vec_h n=%0d", na), va.hcount, tbl[ti].h);
         chk($sformatf("vec_v n=%0d", na), va.vcount, tbl[ti].v);
         chk($sformatf("vec_flags n=%0d", na),
             {va.hsync, va.vsync, va.video_on, va.p_tick},
             {tbl[ti].hs, tbl[ti].vs, tbl[ti].von, tbl[ti].pt});
         ti++;
      end
   endtask

   initial begin
      int   fall[$], rise[$], fs_at[$];
      logic prev_hs;
      int   white, box_bad, mh, mv, k;
      logic box;

      tbl.push_back('{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1});
      tbl.push_back('{2,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{3,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1});
      tbl.push_back('{1279, 639, 0, 1'b1, 1'b1, 1'b1, 1'b1});
      tbl.push_back('{1280, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1311, 655, 0, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1312, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1503, 751, 0, 1'b0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1504, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1599, 799, 0, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1600, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{3199, 799, 1, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{3200, 0,   2, 1'b1, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{4512, 656, 2, 1'b0, 1'b1, 1'b0, 1'b0});

      repeat (3) @(negedge clk);
      check_reset_vals("rst_a", va.hcount, va.vcount, va.hsync, va.vsync, va.video_on,
                       va.p_tick, va.frame_start);
      check_reset_vals("rst_b", vb.hcount, vb.vcount, vb.hsync, vb.vsync, vb.video_on,
                       vb.p_tick, vb.frame_start);

      rst_a = 1'b0;
      rst_b = 1'b0;
      na = 0; nb = 0; ti = 0;
      white = 0; box_bad = 0;
      prev_hs = va.hsync;
      apply_vecs();
      check_b(nb);

      for (int c = 1; c <= 4600; c++) begin
         @(negedge clk);
         na++; nb++;
         apply_vecs();
         check_b(nb);
         if (prev_hs && !va.hsync) fall.push_back(na);
         if (!prev_hs && va.hsync) rise.push_back(na);
         prev_hs = va.hsync;
         if (vb.frame_start) fs_at.push_back(nb);
         // Scaled white box over small-frame pixels h 2..5, v 1..2.
         box = (vb.hcount >= 2 && vb.hcount <= 5 && vb.vcount >= 1 && vb.vcount <= 2);
         if (box && !vb.video_on) box_bad++;
         if (box && vb.video_on && nb >= 240 && nb < 480) white++;
      end

      chk("table_consumed", ti, tbl.size());
      chk("hsync_first_fall", (fall.size() > 0) ? fall[0] : -1, 1312);
      chk("line_period", (fall.size() > 1) ? fall[1] - fall[0] : -1, 1600);
      chk("hsync_low_width", (rise.size() > 0 && fall.size() > 0) ? rise[0] - fall[0] : -1, 192);
      chk("frame_period", (fs_at.size() > 1) ? fs_at[1] - fs_at[0] : -1, 240);
      chk("white_cycles", white, 16);
      chk("box_outside_visible", box_bad, 0);

      // Mid-line reset on the full-size instance at (700,2), off the clock edge.
      chk("pre_reset_h", va.hcount, 700);
      chk("pre_reset_v", va.vcount, 2);
      #2 rst_a = 1'b1;
      #1 check_reset_vals("midrst_a", va.hcount, va.vcount, va.hsync, va.vsync, va.video_on,
                          va.p_tick, va.frame_start);

      // Walk the small instance into both sync pulses, then reset it there.
      model_b(nb, mh, mv);
      for (k = 0; k < 400 && !(mh == 11 && mv == 5); k++) begin
         @(negedge clk);
         nb++;
         check_b(nb);
         model_b(nb, mh, mv);
      end
      chk("reach_sync_low", {vb.hsync, vb.vsync}, 2'b00);
      #2 rst_b = 1'b1;
      #1 check_reset_vals("midrst_b", vb.hcount, vb.vcount, vb.hsync, vb.vsync, vb.video_on,
                          vb.p_tick, vb.frame_start);

      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      nb = 0;
      @(negedge clk);
      nb++;
      chk("rel_tick1", va.p_tick, 1);
      chk("rel_h1", va.hcount, 0);
      check_b(nb);
      @(negedge clk);
      nb++;
      chk("rel_h2", va.hcount, 1);
      chk("rel_tick2", va.p_tick, 0);
      check_b(nb);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
